pak_loader: RTL and testbench

PAK_LOADER -- requirements
Module: pak_loader

---
 rtl/pak_loader_pkg.sv | 21 ++
 rtl/pak_loader_byte_packer.sv | 56 +++++
 rtl/pak_loader.sv | 126 ++++++++++++
 tb/tb_pak_loader.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/pak_loader_pkg.sv
// Shared types and constants for the pak image loader.
// State encoding, pak window size and header geometry.
package pak_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HDR  = 2'd1,
    ST_DATA = 2'd2,
    ST_LAST = 2'd3
  } state_e;

  localparam logic [31:0] MAX_BYTES_DEF = 32'h0200_0000;
  localparam int unsigned HDR_BYTES     = 4;
  localparam int unsigned ADDR_W        = 23;

  // Little-endian accumulate: newest byte enters at the top and migrates down.
  function automatic logic [31:0] le_shift_in(input logic [31:0] acc, input logic [7:0] b);
    return {b, acc[31:8]};
  endfunction

endpackage

// File: rtl/pak_loader_byte_packer.sv
// Packs a byte stream little-endian into 32-bit words; a strobe fires one cycle after
// the 4th byte (or a flushed partial word, zero-padded high). No backpressure.
module byte_packer
  import pak_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        byte_vld,
  input  logic [7:0]  byte_dat,
  input  logic        flush,
  output logic        word_vld,
  output logic [31:0] word_dat
);

  logic [31:0] sr_q;
  logic [1:0]  lane_q;
  logic [31:0] shifted;
  logic [31:0] aligned;
  logic        emit;

  // A partial word sits in the top lanes of the shifter; shift it down so byte 0 lands at [7:0].
  always_comb begin
    shifted = le_shift_in(sr_q, byte_dat);
    aligned = shifted >> {(2'd3 - lane_q), 3'b000};
    emit    = byte_vld && ((lane_q == 2'd3) || flush);
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sr_q   <= '0;
      lane_q <= '0;
    end else if (byte_vld) begin
      if (emit) begin
        sr_q   <= '0;
        lane_q <= '0;
      end else begin
        sr_q   <= shifted;
        lane_q <= lane_q + 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      word_vld <= 1'b0;
      word_dat <= '0;
    end else begin
      word_vld <= emit;
      if (emit) begin
        word_dat <= aligned;
      end
    end
  end

endmodule

// File: rtl/pak_loader.sv
// Loads a length-prefixed byte image into pak memory as 32-bit word writes.
// Write lands one cycle after its last byte; rx has no backpressure, extra bytes are dropped.
module pak_loader
  import pak_loader_pkg::*;
#(
  parameter logic [31:0] MAX_BYTES = MAX_BYTES_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                rx_valid,
  input  logic [7:0]          rx_data,
  output logic                rpg,
  output logic [ADDR_W-1:0]   rpg_addr,
  output logic [31:0]         rpg_data,
  output logic                rpg_write,
  output logic                busy,
  output logic                done,
  output logic                err
);

  state_e            state_q;
  state_e            state_d;
  logic [31:0]       len_q;
  logic [31:0]       cnt_q;
  logic [1:0]        hdr_idx_q;
  logic [ADDR_W-1:0] addr_q;
  logic              done_q;
  logic              err_q;

  logic [31:0]       len_full;
  logic              hdr_acc;
  logic              hdr_done;
  logic              len_bad;
  logic              len_zero;
  logic              pay_acc;
  logic              pay_last;
  logic              clear;
  logic              done_d;
  logic              err_d;

  always_comb begin
    len_full = le_shift_in(len_q, rx_data);
    hdr_acc  = (state_q == ST_HDR) && rx_valid;
    hdr_done = hdr_acc && (hdr_idx_q == 2'(HDR_BYTES - 1));
    len_bad  = len_full > MAX_BYTES;
    len_zero = len_full == 32'd0;
    pay_acc  = (state_q == ST_DATA) && rx_valid;
    // LEN never exceeds MAX_BYTES, so cnt_q + 1 cannot wrap here.
    pay_last = pay_acc && ((cnt_q + 32'd1) == len_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)    state_d = ST_HDR;
      ST_HDR:  if (hdr_done) state_d = (len_bad || len_zero) ? ST_IDLE : ST_DATA;
      ST_DATA: if (pay_last) state_d = ST_LAST;
      ST_LAST:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy   = state_q != ST_IDLE;
    rpg    = state_q != ST_IDLE;
    clear  = (state_q == ST_IDLE) && start;
    err_d  = hdr_done && len_bad;
    done_d = (hdr_done && !len_bad && len_zero) || (state_q == ST_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len_q     <= '0;
      cnt_q     <= '0;
      hdr_idx_q <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      done_q <= done_d;
      err_q  <= err_d;
      if (clear) begin
        len_q     <= '0;
        cnt_q     <= '0;
        hdr_idx_q <= '0;
        addr_q    <= '0;
      end else begin
        if (hdr_acc) begin
          len_q     <= len_full;
          hdr_idx_q <= hdr_idx_q + 2'd1;
        end
        if (pay_acc) begin
          cnt_q <= cnt_q + 32'd1;
        end
        if (rpg_write) begin
          addr_q <= addr_q + 1'b1;
        end
      end
    end
  end

  byte_packer u_packer (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .byte_vld (pay_acc),
    .byte_dat (rx_data),
    .flush    (pay_last),
    .word_vld (rpg_write),
    .word_dat (rpg_data)
  );

  assign rpg_addr = addr_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_pak_loader.sv
// Randomized bench for pak_loader against a byte-list reference model.
module tb_pak_loader;

  localparam logic [31:0] MAXB = 32'h0200_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rpg;
  logic [22:0] rpg_addr;
  logic [31:0] rpg_data;
  logic        rpg_write;
  logic        busy;
  logic        done;
  logic        err;

  pak_loader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rpg       (rpg),
    .rpg_addr  (rpg_addr),
    .rpg_data  (rpg_data),
    .rpg_write (rpg_write),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc_n   = 0;

  logic [22:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          wr_cyc_q  [$];
  logic [7:0]  pay       [$];
  int done_n, err_n, done_cyc, err_cyc, rpg_drop, bad_pulse;
  int track_lo, track_hi;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc_n);
    end
  endtask

  always @(posedge clk) cyc_n <= cyc_n + 1;

  always @(negedge clk) begin
    if (rpg_write) begin
      wr_addr_q.push_back(rpg_addr);
      wr_data_q.push_back(rpg_data);
      wr_cyc_q.push_back(cyc_n);
    end
    if (done) begin done_n++; done_cyc = cyc_n; end
    if (err)  begin err_n++;  err_cyc  = cyc_n; end
    if ((done || err) && (busy || rpg)) bad_pulse++;
    if (cyc_n >= track_lo && cyc_n <= track_hi && !rpg) rpg_drop++;
  end

  task automatic drive(input logic v, input logic [7:0] d, input logic s);
    @(posedge clk); #1;
    rx_valid = v;
    rx_data  = d;
    start    = s;
  endtask

  task automatic gap(input int pct);
    for (int g = 0; g < 2; g++)
      if ($urandom_range(99) < pct) drive(1'b0, 8'h00, 1'b0);
  endtask

  task automatic clear_obs();
    wr_addr_q.delete(); wr_data_q.delete(); wr_cyc_q.delete();
    done_n = 0; err_n = 0; done_cyc = -1; err_cyc = -1;
    rpg_drop = 0; bad_pulse = 0;
    track_lo = 32'h7fffffff; track_hi = 32'h7fffffff;
  endtask

  // Starts a load and sends the 4 header bytes; returns the cycle of the last header byte.
  task automatic send_header(input logic [31:0] len, input int pct, output int hdr_cyc);
    drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b1, 8'($urandom), 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    track_lo = cyc_n + 1;
    for (int i = 0; i < 4; i++) begin
      gap(pct);
      drive(1'b1, len[8*i +: 8], 1'b0);
    end
    hdr_cyc = cyc_n;
  endtask

  task automatic run_load(input logic [31:0] len, input int extra, input bit poke, input int pct);
    int hdr_cyc, last_cyc, nw;
    logic [31:0] e;
    clear_obs();
    send_header(len, pct, hdr_cyc);
    if (len == 0 || len > MAXB) begin
      track_hi = hdr_cyc;
      repeat (5) drive(1'b0, 8'h00, 1'b0);
      chk("hdr_err_cnt",  64'(err_n),  (len > MAXB) ? 64'd1 : 64'd0);
      chk("hdr_done_cnt", 64'(done_n), (len == 0) ? 64'd1 : 64'd0);
      chk("hdr_pulse_cyc", 64'((len == 0) ? done_cyc : err_cyc), 64'(hdr_cyc + 1));
      chk("hdr_writes", 64'(wr_addr_q.size()), 64'd0);
    end else begin
      last_cyc = -1;
      for (int i = 0; i < int'(len) + extra; i++) begin
        if (i < int'(len)) gap(pct);
        drive(1'b1, (i < int'(len)) ? pay[i] : 8'($urandom), poke && (i == int'(len) / 2));
        if (i == int'(len) - 1) begin
          last_cyc = cyc_n;
          track_hi = last_cyc + 1;
        end
      end
      repeat (6) drive(1'b0, 8'h00, 1'b0);
      nw = (int'(len) + 3) / 4;
      chk("wr_count", 64'(wr_addr_q.size()), 64'(nw));
      for (int w = 0; w < nw && w < wr_addr_q.size(); w++) begin
        e = '0;
        for (int j = 0; j < 4; j++)
          if (4 * w + j < int'(len)) e = e | (32'(pay[4*w+j]) << (8 * j));
        chk("wr_addr", 64'(wr_addr_q[w]), 64'(w));
        chk("wr_data", 64'(wr_data_q[w]), 64'(e));
      end
      if (wr_cyc_q.size() > 0) chk("last_wr_cyc", 64'(wr_cyc_q[$]), 64'(last_cyc + 1));
      chk("done_cnt", 64'(done_n), 64'd1);
      chk("done_cyc", 64'(done_cyc), 64'(last_cyc + 2));
      chk("err_cnt",  64'(err_n), 64'd0);
    end
    chk("rpg_drop",   64'(rpg_drop), 64'd0);
    chk("pulse_busy", 64'(bad_pulse), 64'd0);
    chk("idle_busy",  64'({busy, rpg}), 64'd0);
  endtask

  task automatic fill_random(input int n);
    pay.delete();
    for (int i = 0; i < n; i++) pay.push_back(8'($urandom));
  endtask

  function automatic logic [63:0] outs();
    return 64'({rpg, rpg_addr, rpg_data, rpg_write, busy, done, err});
  endfunction

  initial begin
    int hc;
    logic [31:0] w0;
    clear_obs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset_outs", outs(), 64'd0);

    pay = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    run_load(32'd8, 0, 1'b0, 0);
    pay = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    run_load(32'd5, 0, 1'b0, 0);
    run_load(32'h0200_0001, 0, 1'b0, 0);
    run_load(32'd0, 0, 1'b0, 0);
    fill_random(12);
    run_load(32'd12, 3, 1'b1, 0);

    // Abort after 6 of 16 bytes: only the first word may have been written.
    clear_obs();
    fill_random(16);
    send_header(32'd16, 0, hc);
    for (int i = 0; i < 6; i++) drive(1'b1, pay[i], 1'b0);
    @(posedge clk); #1 rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("abort_outs", outs(), 64'd0);
    repeat (4) drive(1'b0, 8'h00, 1'b0);
    w0 = {pay[3], pay[2], pay[1], pay[0]};
    chk("abort_wr_count", 64'(wr_addr_q.size()), 64'd1);
    if (wr_addr_q.size() > 0) begin
      chk("abort_wr_addr", 64'(wr_addr_q[0]), 64'd0);
      chk("abort_wr_data", 64'(wr_data_q[0]), 64'(w0));
    end
    chk("abort_done_err", 64'(done_n + err_n), 64'd0);

    // LEN exactly at the window limit is accepted.
    clear_obs();
    send_header(MAXB, 0, hc);
    drive(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    chk("max_len_busy", 64'({busy, rpg, err}), 64'b110);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("max_len_err_cnt", 64'(err_n), 64'd0);

    for (int t = 0; t < 25; t++) begin
      int l;
      l = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(40, 1));
      fill_random(l);
      run_load(32'(l), int'($urandom_range(3)), 1'($urandom_range(1)),
               ($urandom_range(1) == 1) ? 30 : 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
